apb_cmd_master: RTL
===================

// Module: apb_cmd_master
// PURPOSE
//  APB initiator that drives the accelerator's memory-mapped control registers
//  (weight transfer, last row/col, systolic start, buffer addresses, batch, accumulate).
//  Takes single register commands over a valid/ready interface and runs standard APB SETUP/ACCESS cycles.
//  Returns one response per command, carrying read data, slave error and timeout status.
//  Sits between the host-side command sequencer and the register-file APB slave.
// PARAMETERS
//  ADDR_W   32  APB address width
//  DATA_W   32  APB data width
//  TIMEOUT  16  max ACCESS cycles waiting for pready before abort (>=1)
// PORTS
//  clk             in   1       single clock, all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  cmd_valid       in   1       command request
//  cmd_ready       out  1       command accepted when cmd_valid&cmd_ready
//  cmd_write       in   1       1=write, 0=read
//  cmd_addr        in   ADDR_W  register byte address
//  cmd_wdata       in   DATA_W  write data
//  rsp_valid       out  1       response available
//  rsp_ready       in   1       response consumed when rsp_valid&rsp_ready
//  rsp_rdata       out  DATA_W  captured prdata (0 for writes/timeout)
//  rsp_err         out  1       pslverr seen or timeout
//  rsp_timeout     out  1       transfer aborted by timeout
//  busy            out  1       state != IDLE
//  m_apb_paddr     out  ADDR_W  APB PADDR
//  m_apb_psel      out  1       APB PSEL
//  m_apb_penable   out  1       APB PENABLE
//  m_apb_pwrite    out  1       APB PWRITE
//  m_apb_pwdata    out  DATA_W  APB PWDATA
//  m_apb_pready    in   1       APB PREADY
//  m_apb_prdata    in   DATA_W  APB PRDATA
//  m_apb_pslverr   in   1       APB PSLVERR
// BEHAVIOUR
//  - Reset: state=IDLE. psel, penable, pwrite, rsp_valid, rsp_err and rsp_timeout are 0.
//    paddr, pwdata and rsp_rdata are 0. The timeout counter is 0.
//  - Reset mid-transfer: psel and penable drop at the reset edge. No response is produced.
//  - FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
//  - IDLE: cmd_ready=1 (the only state with cmd_ready=1).
//    On accept, latch addr, wdata and write into the paddr, pwdata and pwrite regs, then go to SETUP.
//  - SETUP (1 cycle): psel=1, penable=0. Next state is ACCESS.
//  - ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable.
//    Counter increments each cycle pready=0.
//    - pready=1: capture prdata (reads only; writes capture 0) and pslverr into rsp_rdata and rsp_err.
//      rsp_timeout=0. Drop psel and penable. Go to RESP.
//    - pready=0 with counter==TIMEOUT-1: abort. Drop psel and penable.
//      rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
//  - RESP: rsp_valid=1, fields held until rsp_ready. On handshake go to IDLE and clear rsp_valid.
//  - Latency: accept at cycle N gives SETUP at N+1 and ACCESS at N+2.
//    With a zero-wait slave, rsp_valid=1 at N+3. Minimum command spacing is 4 cycles.
//  - Exactly one outstanding command. cmd_ready=0 from SETUP through RESP.
//  - psel never asserts without a SETUP cycle first. penable=1 only in ACCESS.
//  - cmd_addr is forwarded unmodified. Unaligned/unmapped decode is the slave's job.
//  - Counter width is clog2(TIMEOUT)+1 and resets on entry to SETUP.
// STRUCTURE
//  - Shared package bnn_apb_pkg holds:
//    - FSM state localparams
//    - register offsets REG_WEIGHT_XFER=0x00, REG_LAST_ROW=0x04, REG_LAST_COL=0x08, REG_SYS_START=0x0C,
//      REG_ACT_ADDR=0x10, REG_BATCH=0x14, REG_PSUM_ADDR=0x18, REG_ACCUM=0x1C
//    - APB default widths
//  - Single flat module. No sub-module needed; the timeout counter stays inline.
// TESTING
//  1 Write 0x1C=1 with zero-wait slave: SETUP then ACCESS (addr 0x1C, pwdata 1, pwrite 1).
//    rsp_valid 3 cycles after accept, rsp_err=0. The slave's accumulate output becomes 1.
//  2 Read 0x04 from the register-file slave (pslverr=1 on reads):
//    rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  3 Slave holds pready=0 for 3 ACCESS cycles with prdata=0xA5A5_0001:
//    response carries 0xA5A5_0001, err=0, and ACCESS lasts exactly 4 cycles.
//  4 pready tied 0, TIMEOUT=16: psel drops after 16 ACCESS cycles. rsp_err=1, rsp_timeout=1.
//  5 Hold rsp_ready=0 for 5 cycles while cmd_valid=1: rsp fields stable and cmd_ready=0.
//    After the handshake, the next command is accepted one cycle later.
//  6 Assert reset in ACCESS: psel, penable and rsp_valid are 0 after the edge.
//    A new command afterwards completes normally.

Source files
------------

// File: rtl/bnn_apb_pkg.sv
// rtl/bnn_apb_pkg.sv - shared APB command master constants: FSM states, register map, default widths
//
// Contents:
//   ST_*        command master FSM state encodings
//   REG_*       accelerator control register byte offsets
//   APB_*_W     default APB address/data widths
package bnn_apb_pkg;

    // Default APB bus widths.
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Command master FSM states.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Accelerator control register byte offsets.
    localparam logic [7:0] REG_WEIGHT_XFER = 8'h00;
    localparam logic [7:0] REG_LAST_ROW    = 8'h04;
    localparam logic [7:0] REG_LAST_COL    = 8'h08;
    localparam logic [7:0] REG_SYS_START   = 8'h0C;
    localparam logic [7:0] REG_ACT_ADDR    = 8'h10;
    localparam logic [7:0] REG_BATCH       = 8'h14;
    localparam logic [7:0] REG_PSUM_ADDR   = 8'h18;
    localparam logic [7:0] REG_ACCUM       = 8'h1C;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB initiator running one register command at a time with a response
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_write/cmd_addr/cmd_wdata  command fields
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response fields (read data, slave error or timeout, timeout)
//   busy                        high whenever a command is in flight or its response is pending
//   m_apb_*                     APB initiator bus (all outputs registered)
module apb_cmd_master
    import bnn_apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] m_apb_paddr,
    output logic              m_apb_psel,
    output logic              m_apb_penable,
    output logic              m_apb_pwrite,
    output logic [DATA_W-1:0] m_apb_pwdata,
    input  logic              m_apb_pready,
    input  logic [DATA_W-1:0] m_apb_prdata,
    input  logic              m_apb_pslverr
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            m_apb_paddr   <= '0;
            m_apb_psel    <= 1'b0;
            m_apb_penable <= 1'b0;
            m_apb_pwrite  <= 1'b0;
            m_apb_pwdata  <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        // psel is raised here so it is already high during the SETUP cycle.
                        m_apb_paddr   <= cmd_addr;
                        m_apb_pwdata  <= cmd_wdata;
                        m_apb_pwrite  <= cmd_write;
                        m_apb_psel    <= 1'b1;
                        m_apb_penable <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    m_apb_penable <= 1'b1;
                    state         <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (m_apb_pready) begin
                        // Writes return zero data so a stale prdata never leaks into a write response.
                        rsp_rdata     <= m_apb_pwrite ? '0 : m_apb_prdata;
                        rsp_err       <= m_apb_pslverr;
                        rsp_timeout   <= 1'b0;
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        state         <= ST_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Slave never answered within TIMEOUT access cycles: abandon the transfer.
                        rsp_rdata     <= '0;
                        rsp_err       <= 1'b1;
                        rsp_timeout   <= 1'b1;
                        m_apb_psel    <= 1'b0;
                        m_apb_penable <= 1'b0;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    m_apb_psel    <= 1'b0;
                    m_apb_penable <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
